// File: rtl/cpu_io_top.sv
// I/O shell of the ray-tracing CPU: word-serial loader with checksum, byte-serial responder.
// Define CPU_IO_ECHO_EN to echo the buffered payload before the checksum bytes.
module cpu_io_top #(
  parameter int DEPTH  = 16,
  parameter int TX_GAP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] recvdata,
  input  logic        recv_valid,
  output logic [7:0]  ansdata2,
  output logic        valid2,
  output logic        readflag
);

  localparam int NW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(4 * DEPTH + 5);
  localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_TX   = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [NW-1:0]   n_r, n_s, idx_r, idx_s, hdr_n_s;
  logic [31:0]     checksum_r, checksum_s, sum_s;
  logic [CW-1:0]   tx_cnt_r, tx_cnt_s, tot_s;
  logic [GW-1:0]   gap_r, gap_s;
  logic            readflag_r, readflag_s, valid2_r, valid2_s;
  logic [7:0]      ansdata2_r, ansdata2_s, first_byte_s, tx_byte_s;
  logic            accept_s, last_word_s;

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] lane);
    byte_sel = word[8*lane +: 8];
  endfunction

  assign accept_s    = readflag_r & recv_valid;
  assign sum_s       = checksum_r + recvdata;
  assign last_word_s = (idx_r == (n_r - NW'(1'b1)));
  assign hdr_n_s     = ({24'h000000, recvdata[7:0]} > 32'(DEPTH)) ? NW'(DEPTH) : NW'(recvdata[7:0]);

`ifdef CPU_IO_ECHO_EN
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [31:0] mem_r [DEPTH];
  logic        wr_en_s;

  assign wr_en_s = (state_r == S_DATA) && accept_s;

  // Payload store; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[idx_r[AW-1:0]] <= recvdata;
  end

  // Word 0 may be arriving on the same edge that starts transmission (N=1)
  assign tot_s        = CW'({n_r, 2'b00}) + CW'(32'd4);
  assign first_byte_s = (idx_r == {NW{1'b0}}) ? recvdata[7:0] : mem_r[0][7:0];
  assign tx_byte_s    = (tx_cnt_r < CW'({n_r, 2'b00})) ?
                        byte_sel(mem_r[tx_cnt_r[AW+1:2]], tx_cnt_r[1:0]) :
                        byte_sel(checksum_r, tx_cnt_r[1:0]);
`else
  assign tot_s        = CW'(32'd4);
  assign first_byte_s = sum_s[7:0];
  assign tx_byte_s    = byte_sel(checksum_r, tx_cnt_r[1:0]);
`endif

  // Next-state and output decode
  always_comb begin
    state_s    = state_r;
    n_s        = n_r;
    idx_s      = idx_r;
    checksum_s = checksum_r;
    tx_cnt_s   = tx_cnt_r;
    gap_s      = gap_r;
    readflag_s = 1'b0;
    valid2_s   = 1'b0;
    ansdata2_s = ansdata2_r;
    case (state_r)
      S_HDR: begin
        if (accept_s) begin
          n_s        = hdr_n_s;
          idx_s      = {NW{1'b0}};
          checksum_s = 32'h0000_0000;
          if (hdr_n_s == {NW{1'b0}}) begin
            state_s    = S_TX;
            valid2_s   = 1'b1;
            ansdata2_s = 8'h00;
            tx_cnt_s   = CW'(1'b1);
            gap_s      = {GW{1'b0}};
          end else begin
            state_s = S_DATA;
          end
        end else begin
          readflag_s = 1'b1;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          checksum_s = sum_s;
          idx_s      = idx_r + NW'(1'b1);
          if (last_word_s) begin
            state_s    = S_TX;
            valid2_s   = 1'b1;
            ansdata2_s = first_byte_s;
            tx_cnt_s   = CW'(1'b1);
            gap_s      = {GW{1'b0}};
          end else begin
            state_s = S_DATA;
          end
        end else begin
          readflag_s = 1'b1;
        end
      end
      S_TX: begin
        // Same gap terminates both byte spacing and the trailing idle period
        if (gap_r == GW'(TX_GAP - 1)) begin
          gap_s = {GW{1'b0}};
          if (tx_cnt_r < tot_s) begin
            valid2_s   = 1'b1;
            ansdata2_s = tx_byte_s;
            tx_cnt_s   = tx_cnt_r + CW'(1'b1);
          end else begin
            state_s    = S_HDR;
            readflag_s = 1'b1;
          end
        end else begin
          gap_s = gap_r + GW'(1'b1);
        end
      end
      default: begin
        state_s = S_HDR;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_HDR;
      n_r        <= {NW{1'b0}};
      idx_r      <= {NW{1'b0}};
      checksum_r <= 32'h0000_0000;
      tx_cnt_r   <= {CW{1'b0}};
      gap_r      <= {GW{1'b0}};
      readflag_r <= 1'b0;
      valid2_r   <= 1'b0;
      ansdata2_r <= 8'h00;
    end else begin
      state_r    <= state_s;
      n_r        <= n_s;
      idx_r      <= idx_s;
      checksum_r <= checksum_s;
      tx_cnt_r   <= tx_cnt_s;
      gap_r      <= gap_s;
      readflag_r <= readflag_s;
      valid2_r   <= valid2_s;
      ansdata2_r <= ansdata2_s;
    end
  end

  assign readflag = readflag_r;
  assign valid2   = valid2_r;
  assign ansdata2 = ansdata2_r;

endmodule

// File: tb/tb_cpu_io_top.sv
// Directed self-checking bench for cpu_io_top (DEPTH=16, TX_GAP=4), both CPU_IO_ECHO_EN builds.
module tb_cpu_io_top;

  localparam int TX_GAP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] recvdata;
  logic        recv_valid;
  logic [7:0]  ansdata2;
  logic        valid2;
  logic        readflag;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q [$];
  int         rx_t [$];
  logic [7:0] exp_q [$];
  int         cyc = 0;
  int         rf_rise_t = -1;
  logic       rf_prev = 1'b0;

  cpu_io_top #(.DEPTH(16), .TX_GAP(TX_GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .recvdata   (recvdata),
    .recv_valid (recv_valid),
    .ansdata2   (ansdata2),
    .valid2     (valid2),
    .readflag   (readflag)
  );

  always #5 clk = ~clk;

  // Byte/pulse-time recorder and readflag rise detector
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (valid2) begin
      rx_q.push_back(ansdata2);
      rx_t.push_back(cyc);
    end
    if (readflag && !rf_prev) rf_rise_t <= cyc;
    rf_prev <= readflag;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic send_word(input logic [31:0] w);
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!readflag && waited < 200);
    check("send_ready", 32'(readflag), 32'd1);
    recvdata   = w;
    recv_valid = 1'b1;
    @(negedge clk);
    recv_valid = 1'b0;
  endtask

  task automatic expect_stream(input string tag);
    int n = exp_q.size();
    int w = 0;
    while (w < 2000) begin
      @(negedge clk);
      w++;
      if (rx_t.size() >= n && rx_t.size() > 0 && rf_rise_t > rx_t[rx_t.size()-1]) break;
    end
    check({tag, "_done"}, 32'(w < 2000), 32'd1);
    check({tag, "_cnt"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size()) begin
        check($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        if (i > 0) check($sformatf("%s_gap%0d", tag, i), 32'(rx_t[i] - rx_t[i-1]), 32'(TX_GAP));
      end
    end
    if (rx_t.size() > 0)
      check({tag, "_rf_back"}, 32'(rf_rise_t - rx_t[rx_t.size()-1]), 32'(TX_GAP));
  endtask

  initial begin
    int k;
    reset      = 1'b0;
    recv_valid = 1'b0;
    recvdata   = 32'h0;

    // 1: reset state and release
    repeat (3) @(negedge clk);
    check("rst_rf", 32'(readflag), 32'd0);
    check("rst_v2", 32'(valid2), 32'd0);
    check("rst_data", 32'(ansdata2), 32'h00);
    reset = 1'b1;
    #1 check("rel_rf0", 32'(readflag), 32'd0);
    @(negedge clk);
    check("rel_rf1", 32'(readflag), 32'd1);

    // 2: two-word payload
    clear_rx();
    send_word(32'h0000_0002);
    send_word(32'h1122_3344);
    send_word(32'h0000_0001);
`ifdef CPU_IO_ECHO_EN
    exp_q = {8'h44, 8'h33, 8'h22, 8'h11, 8'h01, 8'h00, 8'h00, 8'h00, 8'h45, 8'h33, 8'h22, 8'h11};
`else
    exp_q = {8'h45, 8'h33, 8'h22, 8'h11};
`endif
    expect_stream("pay2");

    // 3: empty payload, then a fresh header is accepted
    clear_rx();
    send_word(32'h0000_0000);
    exp_q = {8'h00, 8'h00, 8'h00, 8'h00};
    expect_stream("hdr0");

    // 4: checksum wrap
    clear_rx();
    send_word(32'h0000_0002);
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0002);
`ifdef CPU_IO_ECHO_EN
    exp_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
`else
    exp_q = {8'h01, 8'h00, 8'h00, 8'h00};
`endif
    expect_stream("wrap");

    // 5: recv_valid while readflag=0 (gap cycle and S_TX) is ignored
    clear_rx();
    send_word(32'h0000_0001);
    recvdata   = 32'h1234_5678;
    recv_valid = 1'b1;
    check("rf_gap", 32'(readflag), 32'd0);
    @(negedge clk);
    recv_valid = 1'b0;
    send_word(32'h0000_00AA);
    for (int i = 0; i < 6; i++) begin
      recvdata   = 32'h0000_0003;
      recv_valid = 1'b1;
      check($sformatf("rf_tx%0d", i), 32'(readflag), 32'd0);
      @(negedge clk);
    end
    recv_valid = 1'b0;
`ifdef CPU_IO_ECHO_EN
    exp_q = {8'hAA, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00};
`else
    exp_q = {8'hAA, 8'h00, 8'h00, 8'h00};
`endif
    expect_stream("ignore");

    // Clamp: header 0xFF takes exactly 16 words (1..16, sum 0x88)
    clear_rx();
    send_word(32'h0000_00FF);
    for (int i = 0; i < 16; i++) send_word(32'(i + 1));
    exp_q.delete();
`ifdef CPU_IO_ECHO_EN
    for (int i = 0; i < 16; i++) exp_q = {exp_q, 8'(i + 1), 8'h00, 8'h00, 8'h00};
`endif
    exp_q = {exp_q, 8'h88, 8'h00, 8'h00, 8'h00};
    expect_stream("clamp");

    // 6: reset during the third transmitted byte
    clear_rx();
    send_word(32'h0000_0002);
    send_word(32'h0102_0304);
    send_word(32'h0506_0708);
    k = 0;
    for (int i = 0; i < 500 && k < 3; i++) begin
      if (valid2) k++;
      if (k < 3) @(negedge clk);
    end
    check("rst_tx_seen3", 32'(k), 32'd3);
    reset = 1'b0;
    #1;
    check("rst_tx_v2", 32'(valid2), 32'd0);
    check("rst_tx_rf", 32'(readflag), 32'd0);
    check("rst_tx_data", 32'(ansdata2), 32'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_rx();
    send_word(32'h0000_0000);
    exp_q = {8'h00, 8'h00, 8'h00, 8'h00};
    expect_stream("rst_hdr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
